weight_loader: RTL and testbench
================================

# weight_loader

Sits directly downstream of the weight controller and weight SRAM. Captures weight-SRAM read data returned for each asserted weight read enable, buffers whole rows in a FIFO, and once a complete MAC_ROW-row tile is buffered and the MAC array is ready, shifts the tile into the array one row per cycle and then pulses a latch strobe. It also returns an almost-full back-pressure signal to the controller side.

## Interface
- MAC_ROW, 16, rows per weight tile (rows shifted per load)
- MAC_COL, 16, weights per row
- W_BITWIDTH, 8, bits per weight
- SRAM_LATENCY, 1, cycles from read enable to valid read data (≥1)
- FIFO_DEPTH, 32, row entries; must be ≥ MAC_ROW
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- w_read_en_in  in  1  weight SRAM read enable issued by the weight controller
- w_rdata_in  in  MAC_COL*W_BITWIDTH  SRAM read data, valid SRAM_LATENCY cycles after w_read_en_in
- arr_ready_in  in  1  MAC array can accept a new weight tile
- w_almost_full_out  out  1  back-pressure to controller
- w_shift_out  out  MAC_COL*W_BITWIDTH  row being shifted into the array
- w_shift_valid_out  out  1  w_shift_out valid this cycle
- w_latch_out  out  1  one-cycle strobe: tile complete, array latches weights
- tile_count_out  out  16  tiles delivered since reset, wraps 0xFFFF→0
- w_err_out  out  1  sticky overflow error (see Configuration)

## Operation
- Capture: w_read_en_in delayed through an SRAM_LATENCY-stage valid pipe; when the delayed valid is 1, push w_rdata_in into the row FIFO.
- inflight = number of 1s in the valid pipe; w_almost_full_out = (fifo_count + inflight) ≥ FIFO_DEPTH − 1, combinational from registers.
- Push while FIFO full (fifo_count == FIFO_DEPTH and no pop that cycle): row dropped, fifo_count unchanged.
- Simultaneous push and pop: fifo_count unchanged, both complete.
- Drain FSM states IDLE, SHIFT, LATCH:
  - IDLE→SHIFT when arr_ready_in == 1 and fifo_count ≥ MAC_ROW; row_cnt ← 0.
  - SHIFT: pop one row per cycle into w_shift_out, w_shift_valid_out=1; row_cnt increments; after row MAC_ROW−1 → LATCH. arr_ready_in ignored once in SHIFT (tile always completes, no gaps).
  - LATCH: w_latch_out=1 for one cycle, tile_count_out increments, → IDLE.
- Rows exit in arrival order. w_shift_out = 0 whenever w_shift_valid_out = 0.
- Reset (any time, including mid-SHIFT): FSM IDLE, FIFO emptied, valid pipe cleared, row_cnt 0; all outputs 0 (w_almost_full_out 0, tile_count_out 0, w_err_out 0).

## Timing
- Read enable at edge N → push at edge N+SRAM_LATENCY.
- IDLE condition true at edge E → w_shift_valid_out high for cycles after edges E+1 … E+MAC_ROW (registered outputs); w_latch_out high after edge E+MAC_ROW+1; IDLE re-evaluated at edge E+MAC_ROW+2.
- Back-to-back tiles: period MAC_ROW+2 cycles.
- Tile becoming available and arr_ready_in rising in the same cycle: start at that edge, no extra delay.

## Configuration
- WEIGHT_LOADER_OVF_CHECK_EN defined: w_err_out sets on any dropped push (full FIFO) and on a pop with empty FIFO (unreachable by design; guards FSM bugs); cleared only by rst.
- Not defined: detection logic absent, w_err_out tied 0; drop behaviour unchanged.

## Structure
- Package weight_loader_pkg: state enum typedef (IDLE, SHIFT, LATCH), row typedef logic [MAC_COL*W_BITWIDTH-1:0], default parameter constants.
- One sub-module weight_loader_row_fifo: synchronous FIFO (push, pop, data in/out, count, full, empty), same clk/rst.

## Test plan
- Reset: hold rst 3 cycles with read enables toggling → all outputs 0, no pushes; release → idle, count 0.
- Single tile: 16 consecutive read enables with rows 0x00..0x0F patterns, arr_ready_in=1 → 16 valid rows in order starting 2 cycles after last read enable arrives (SRAM_LATENCY=1), latch strobe next cycle, tile_count_out=1.
- Not ready: fill 16 rows, arr_ready_in=0 for 20 cycles → no shift; raise ready → shift starts next edge.
- Back-to-back: 32 rows buffered, ready held → two tiles, latch strobes 18 cycles apart, tile_count_out=2.
- Overflow: 34 read enables, ready=0 → w_almost_full_out high once count+inflight ≥31, rows 33–34 dropped, w_err_out=1 (macro defined) / 0 (undefined).
- Reset mid-SHIFT at row 7 → valid drops next cycle, no latch strobe, FIFO empty, tile_count_out 0.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// weight_loader shared types and default geometry.
package weight_loader_pkg;

  localparam int DEF_MAC_ROW      = 16;
  localparam int DEF_MAC_COL      = 16;
  localparam int DEF_W_BITWIDTH   = 8;
  localparam int DEF_SRAM_LATENCY = 1;
  localparam int DEF_FIFO_DEPTH   = 32;

  typedef logic [DEF_MAC_COL*DEF_W_BITWIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

endpackage

// File: rtl/weight_loader_row_fifo.sv
// Synchronous row FIFO with occupancy count.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module weight_loader_row_fifo
  import weight_loader_pkg::*;
#(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Buffers weight-SRAM rows and shifts whole tiles into the MAC array.
// Define WEIGHT_LOADER_OVF_CHECK_EN to enable the sticky overflow/underflow flag.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int MAC_ROW      = DEF_MAC_ROW,
  parameter int MAC_COL      = DEF_MAC_COL,
  parameter int W_BITWIDTH   = DEF_W_BITWIDTH,
  parameter int SRAM_LATENCY = DEF_SRAM_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_read_en_in,
  input  logic [MAC_COL*W_BITWIDTH-1:0] w_rdata_in,
  input  logic                          arr_ready_in,
  output logic                          w_almost_full_out,
  output logic [MAC_COL*W_BITWIDTH-1:0] w_shift_out,
  output logic                          w_shift_valid_out,
  output logic                          w_latch_out,
  output logic [15:0]                   tile_count_out,
  output logic                          w_err_out
);

  localparam int RW  = MAC_COL * W_BITWIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int RCW = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;

  localparam logic [RCW-1:0] LAST_ROW  = RCW'(MAC_ROW - 1);
  localparam logic [CW-1:0]  TILE_ROWS = CW'(MAC_ROW);

  logic [SRAM_LATENCY-1:0] vld_pipe;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           fifo_count;
  logic [RW-1:0]           fifo_dout;
  int                      occupancy;
  state_t                  state;
  logic [RCW-1:0]          row_cnt;

  assign push = vld_pipe[SRAM_LATENCY-1];
  assign pop  = (state == SHIFT);

  // Rows already requested count against capacity before they land.
  assign occupancy         = int'(fifo_count) + $countones(vld_pipe);
  assign w_almost_full_out = (occupancy >= FIFO_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= w_read_en_in;
      for (int i = 1; i < SRAM_LATENCY; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  weight_loader_row_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (w_rdata_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      row_cnt           <= '0;
      w_shift_out       <= '0;
      w_shift_valid_out <= 1'b0;
      w_latch_out       <= 1'b0;
      tile_count_out    <= '0;
    end else begin
      w_shift_out       <= '0;
      w_shift_valid_out <= 1'b0;
      w_latch_out       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arr_ready_in && (fifo_count >= TILE_ROWS)) begin
            state   <= SHIFT;
            row_cnt <= '0;
          end
        end
        SHIFT: begin
          w_shift_out       <= fifo_dout;
          w_shift_valid_out <= 1'b1;
          row_cnt           <= row_cnt + 1'b1;
          if (row_cnt == LAST_ROW) state <= LATCH;
        end
        LATCH: begin
          w_latch_out    <= 1'b1;
          tile_count_out <= tile_count_out + 16'd1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_LOADER_OVF_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      w_err_out <= 1'b0;
    else if ((push && full && !pop) || (pop && empty))
      w_err_out <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = full ^ empty;
  assign w_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected rows queued at issue,
// a negedge monitor pops and compares every shifted row and latch strobe.
module tb_weight_loader;
  import weight_loader_pkg::*;

`ifdef WEIGHT_LOADER_OVF_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_read_en_in = 1'b0;
  row_t        w_rdata_in = '0;
  logic        arr_ready_in = 1'b0;
  logic        w_almost_full_out;
  row_t        w_shift_out;
  logic        w_shift_valid_out;
  logic        w_latch_out;
  logic [15:0] tile_count_out;
  logic        w_err_out;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   latches = 0;
  int   valid_cnt = 0;
  int   rows_in_tile = 0;
  int   tiles_model = 0;
  int   first_cyc [16];
  int   latch_cyc [16];
  row_t exp_q [$];
  row_t pend = '0;
  bit   pend_v = 1'b0;

  weight_loader dut (
    .clk               (clk),
    .rst               (rst),
    .w_read_en_in      (w_read_en_in),
    .w_rdata_in        (w_rdata_in),
    .arr_ready_in      (arr_ready_in),
    .w_almost_full_out (w_almost_full_out),
    .w_shift_out       (w_shift_out),
    .w_shift_valid_out (w_shift_valid_out),
    .w_latch_out       (w_latch_out),
    .tile_count_out    (tile_count_out),
    .w_err_out         (w_err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic row_t mk(input logic [7:0] b);
    row_t r;
    for (int j = 0; j < DEF_MAC_COL; j++)
      r[j*8 +: 8] = b + 8'(j);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: SRAM data for the previous enable appears the cycle after it.
  task automatic drive(input logic en, input row_t d);
    @(negedge clk);
    #1;
    w_read_en_in = en;
    w_rdata_in   = pend_v ? pend : '0;
    pend         = d;
    pend_v       = en;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  task automatic wait_lat(input int target, input int budget);
    int n = 0;
    while (latches < target && n < budget) begin
      drive(1'b0, '0);
      n++;
    end
    chk("latch_wait", latches, target);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rows_in_tile = 0;
      tiles_model  = 0;
    end else begin
      if (w_shift_valid_out) begin
        valid_cnt++;
        if (rows_in_tile == 0 && latches < 16) first_cyc[latches] = cyc;
        rows_in_tile++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL row_unexpected: got %0h expected none", w_shift_out);
        end else begin
          chk("row", w_shift_out, exp_q.pop_front());
        end
      end else begin
        chk("shift_idle_zero", w_shift_out, '0);
      end
      if (w_latch_out) begin
        chk("tile_rows", rows_in_tile, 16);
        tiles_model++;
        chk("tile_count", tile_count_out, 16'(tiles_model));
        if (latches < 16) latch_cyc[latches] = cyc;
        latches++;
        rows_in_tile = 0;
      end
    end
  end

  initial begin
    int l_edge;
    int r_edge;
    int v0;
    int l0;
    int n;

    // Reset with enables toggling
    for (int i = 0; i < 3; i++) begin
      drive(i[0] ? 1'b0 : 1'b1, mk(8'hEE));
      chk("reset_ctrl", {w_shift_valid_out, w_latch_out, w_almost_full_out,
          w_err_out, tile_count_out}, '0);
      chk("reset_shift", w_shift_out, '0);
    end
    drive(1'b0, '0);
    rst = 1'b0;
    pend_v = 1'b0;
    arr_ready_in = 1'b1;
    idle(10);
    chk("post_reset_noshift", valid_cnt, 0);
    chk("post_reset_af", w_almost_full_out, 1'b0);
    chk("post_reset_tiles", tile_count_out, 16'd0);

    // Single tile with ready held
    l_edge = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mk(8'(i)));
      exp_q.push_back(mk(8'(i)));
      l_edge = cyc + 1;
    end
    wait_lat(1, 60);
    chk("t1_first_valid", first_cyc[0], l_edge + 3);
    chk("t1_latch", latch_cyc[0], l_edge + 19);
    idle(2);

    // Tile buffered while array not ready
    arr_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mk(8'(8'h10 + i)));
      exp_q.push_back(mk(8'(8'h10 + i)));
    end
    v0 = valid_cnt;
    idle(20);
    chk("t2_no_shift", valid_cnt, v0);
    drive(1'b0, '0);
    arr_ready_in = 1'b1;
    r_edge = cyc + 1;
    wait_lat(2, 60);
    chk("t2_first_valid", first_cyc[1], r_edge + 1);
    chk("t2_latch", latch_cyc[1], r_edge + 17);

    // Two tiles back to back
    arr_ready_in = 1'b0;
    idle(2);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, mk(8'(8'h20 + i)));
      exp_q.push_back(mk(8'(8'h20 + i)));
    end
    idle(3);
    chk("t3_af_full", w_almost_full_out, 1'b1);
    drive(1'b0, '0);
    arr_ready_in = 1'b1;
    r_edge = cyc + 1;
    wait_lat(4, 100);
    chk("t3_first_valid", first_cyc[2], r_edge + 1);
    chk("t3_latch_gap", latch_cyc[3] - latch_cyc[2], 18);
    chk("t3_tiles", tile_count_out, 16'd4);
    idle(2);

    // Overflow: 34 enables, last two rows dropped
    arr_ready_in = 1'b0;
    chk("t4_err_clear", w_err_out, 1'b0);
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, mk(8'(8'h40 + i)));
      if (i < 32) exp_q.push_back(mk(8'(8'h40 + i)));
      if (i == 30) chk("t4_af_30", w_almost_full_out, 1'b0);
      if (i == 31) chk("t4_af_31", w_almost_full_out, 1'b1);
      if (i == 33) chk("t4_err_before_drop", w_err_out, 1'b0);
    end
    idle(3);
    chk("t4_err", w_err_out, EXP_ERR);
    chk("t4_af_held", w_almost_full_out, 1'b1);
    drive(1'b0, '0);
    arr_ready_in = 1'b1;
    wait_lat(6, 100);
    idle(2);
    chk("t4_af_drained", w_almost_full_out, 1'b0);
    chk("t4_err_sticky", w_err_out, EXP_ERR);
    chk("t4_q_empty", exp_q.size(), 0);

    // Reset in the middle of a tile
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mk(8'(8'h80 + i)));
      exp_q.push_back(mk(8'(8'h80 + i)));
    end
    n = 0;
    while (rows_in_tile < 8 && n < 80) begin
      drive(1'b0, '0);
      n++;
    end
    chk("t5_reached_row7", rows_in_tile, 8);
    rst = 1'b1;
    exp_q.delete();
    l0 = latches;
    drive(1'b0, '0);
    chk("t5_reset_ctrl", {w_shift_valid_out, w_latch_out, w_almost_full_out,
        w_err_out, tile_count_out}, '0);
    chk("t5_reset_shift", w_shift_out, '0);
    rst = 1'b0;
    v0 = valid_cnt;
    idle(30);
    chk("t5_no_shift", valid_cnt, v0);
    chk("t5_no_latch", latches, l0);
    chk("t5_tiles", tile_count_out, 16'd0);
    chk("t5_af", w_almost_full_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
